// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: redirect/stall/debug controls into the PC unit and
// PC, history and status back out to IF, IF/ID and the debug unit.
interface pc_unit_if #(
    parameter int MSB        = 32,
    parameter int HIST_DEPTH = 8
);
    localparam int IDXW = $clog2(HIST_DEPTH);

    logic            i_stall;
    logic            i_branch_taken;
    logic [MSB-1:0]  i_branch_target;
    logic            i_jump;
    logic [MSB-1:0]  i_jump_target;
    logic            i_halt_detect;
    logic            i_dbg_cont;
    logic            i_dbg_step;
    logic [IDXW-1:0] i_hist_idx;
    logic [MSB-1:0]  o_pc;
    logic [MSB-1:0]  o_pc_plus4;
    logic            o_halted;
    logic            o_step_done;
    logic [31:0]     o_upd_count;
    logic [MSB-1:0]  o_hist_pc;

    modport master (
        output i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
               i_halt_detect, i_dbg_cont, i_dbg_step, i_hist_idx,
        input  o_pc, o_pc_plus4, o_halted, o_step_done, o_upd_count, o_hist_pc
    );

    modport slave (
        input  i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
               i_halt_detect, i_dbg_cont, i_dbg_step, i_hist_idx,
        output o_pc, o_pc_plus4, o_halted, o_step_done, o_upd_count, o_hist_pc
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection, debug run/step/halt FSM
// and update counter. Define PC_HISTORY_EN to add the circular PC history buffer.
module pc_unit #(
    parameter int             MSB         = 32,
    parameter logic [MSB-1:0] RESET_PC    = '0,
    parameter int             INSTR_BYTES = 4,
    parameter int             HIST_DEPTH  = 8
) (
    input  logic     i_clk,
    input  logic     i_rst,
    pc_unit_if.slave pc_bus
);
    localparam int             IDXW = $clog2(HIST_DEPTH);
    localparam logic [MSB-1:0] INC  = MSB'(INSTR_BYTES);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [MSB-1:0] pc_q;
    logic [MSB-1:0] pc_next;
    logic [MSB-1:0] pc_plus;
    logic [31:0]    upd_count_q;
    logic           step_done_q;
    logic           active;
    logic           update;

    assign pc_plus = pc_q + INC;

    // A redirect overrides a stall so a pipeline flush is never dropped;
    // a decoded HALT blocks everything, including redirects.
    always_comb begin
        active = (state == ST_RUN || state == ST_STEP) && !pc_bus.i_halt_detect;
        update = active && (!pc_bus.i_stall || pc_bus.i_branch_taken || pc_bus.i_jump);
    end

    always_comb begin
        pc_next = pc_q;
        if (update) begin
            if (pc_bus.i_branch_taken)
                pc_next = pc_bus.i_branch_target;
            else if (pc_bus.i_jump)
                pc_next = pc_bus.i_jump_target;
            else
                pc_next = pc_plus;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: begin
                if (pc_bus.i_dbg_cont)
                    state_next = ST_RUN;
                else if (pc_bus.i_dbg_step)
                    state_next = ST_STEP;
            end
            ST_RUN: begin
                if (pc_bus.i_halt_detect)
                    state_next = ST_HALT;
            end
            ST_STEP: begin
                if (pc_bus.i_halt_detect)
                    state_next = ST_HALT;
                else if (update)
                    state_next = ST_WAIT;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_WAIT;
        endcase
    end

    always_comb begin
        pc_bus.o_halted    = (state == ST_HALT);
        pc_bus.o_step_done = step_done_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            upd_count_q <= '0;
            step_done_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            step_done_q <= (state == ST_STEP) && update;
            if (update)
                upd_count_q <= upd_count_q + 32'd1;
        end
    end

    assign pc_bus.o_pc        = pc_q;
    assign pc_bus.o_pc_plus4  = pc_plus;
    assign pc_bus.o_upd_count = upd_count_q;

`ifdef PC_HISTORY_EN
    logic [MSB-1:0]  hist_mem [HIST_DEPTH];
    logic [IDXW-1:0] head_q;
    logic [IDXW-1:0] rd_idx;

    // Head points at the next free slot, so the newest entry sits at head-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++)
                hist_mem[i] <= '0;
        end else if (update) begin
            hist_mem[head_q] <= pc_q;
            head_q           <= head_q + IDXW'(1);
        end
    end

    always_comb begin
        rd_idx = head_q - IDXW'(1) - pc_bus.i_hist_idx;
    end

    assign pc_bus.o_hist_pc = hist_mem[rd_idx];
`else
    logic unused_hist_idx;
    assign unused_hist_idx  = ^pc_bus.i_hist_idx;
    assign pc_bus.o_hist_pc = '0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a 32-bit instance for the main
// scenarios and an 8-bit instance (RESET_PC=0xFC) for wrap-around.
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.MSB(32), .HIST_DEPTH(8)) bus  ();
    pc_unit_if #(.MSB(8),  .HIST_DEPTH(4)) bus8 ();

    pc_unit #(.MSB(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .HIST_DEPTH(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .pc_bus (bus.slave)
    );

    pc_unit #(.MSB(8), .RESET_PC(8'hFC), .INSTR_BYTES(4), .HIST_DEPTH(4)) dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .pc_bus (bus8.slave)
    );

`ifdef PC_HISTORY_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_stall = 0;  bus.i_branch_taken = 0;  bus.i_branch_target = '0;
        bus.i_jump = 0;   bus.i_jump_target = '0;  bus.i_halt_detect = 0;
        bus.i_dbg_cont = 0; bus.i_dbg_step = 0;    bus.i_hist_idx = '0;
        bus8.i_stall = 0; bus8.i_branch_taken = 0; bus8.i_branch_target = '0;
        bus8.i_jump = 0;  bus8.i_jump_target = '0; bus8.i_halt_detect = 0;
        bus8.i_dbg_cont = 0; bus8.i_dbg_step = 0;  bus8.i_hist_idx = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        n_checks++; if (bus.o_pc_plus4 !== 32'h4) $display("[TB] FAIL reset_plus4: got %h, expected %h", bus.o_pc_plus4, 32'h4); else n_pass++;
        n_checks++; if (bus.o_halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b, expected 0", bus.o_halted); else n_pass++;
        n_checks++; if (bus.o_step_done !== 1'b0) $display("[TB] FAIL reset_step_done: got %b, expected 0", bus.o_step_done); else n_pass++;
        n_checks++; if (bus.o_upd_count !== 32'd0) $display("[TB] FAIL reset_count: got %0d, expected 0", bus.o_upd_count); else n_pass++;
        n_checks++; if (bus.o_hist_pc !== 32'h0) $display("[TB] FAIL reset_hist: got %h, expected %h", bus.o_hist_pc, 32'h0); else n_pass++;
        n_checks++; if (bus8.o_pc !== 8'hFC) $display("[TB] FAIL reset_pc8: got %h, expected %h", bus8.o_pc, 8'hFC); else n_pass++;
        n_checks++; if (bus8.o_pc_plus4 !== 8'h00) $display("[TB] FAIL reset_plus4_8: got %h, expected %h", bus8.o_pc_plus4, 8'h00); else n_pass++;
        tick();
        tick();
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL wait_hold_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc;
        bus.i_dbg_cont = 1'b1;
        tick();
        bus.i_dbg_cont = 1'b0;
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL run_enter_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_pc = 32'(4 * i);
            n_checks++; if (bus.o_pc !== exp_pc) $display("[TB] FAIL run_pc_%0d: got %h, expected %h", i, bus.o_pc, exp_pc); else n_pass++;
        end
        n_checks++; if (bus.o_upd_count !== 32'd4) $display("[TB] FAIL run_count: got %0d, expected 4", bus.o_upd_count); else n_pass++;
        n_checks++; if (bus.o_step_done !== 1'b0) $display("[TB] FAIL run_step_done: got %b, expected 0", bus.o_step_done); else n_pass++;
        bus.i_hist_idx = 3'd0;
        #1;
        exp_pc = HIST_ON ? 32'hC : 32'h0;
        n_checks++; if (bus.o_hist_pc !== exp_pc) $display("[TB] FAIL hist_idx0: got %h, expected %h", bus.o_hist_pc, exp_pc); else n_pass++;
        bus.i_hist_idx = 3'd3;
        #1;
        exp_pc = 32'h0;
        n_checks++; if (bus.o_hist_pc !== exp_pc) $display("[TB] FAIL hist_idx3: got %h, expected %h", bus.o_hist_pc, exp_pc); else n_pass++;
        bus.i_hist_idx = 3'd2;
        #1;
        exp_pc = HIST_ON ? 32'h4 : 32'h0;
        n_checks++; if (bus.o_hist_pc !== exp_pc) $display("[TB] FAIL hist_idx2: got %h, expected %h", bus.o_hist_pc, exp_pc); else n_pass++;
        bus.i_hist_idx = 3'd0;
    endtask

    task automatic test_stall_redirect();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.o_pc !== 32'h10) $display("[TB] FAIL stall_hold_%0d: got %h, expected %h", i, bus.o_pc, 32'h10); else n_pass++;
        end
        n_checks++; if (bus.o_upd_count !== 32'd4) $display("[TB] FAIL stall_count: got %0d, expected 4", bus.o_upd_count); else n_pass++;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h80;
        tick();
        n_checks++; if (bus.o_pc !== 32'h80) $display("[TB] FAIL stall_branch_pc: got %h, expected %h", bus.o_pc, 32'h80); else n_pass++;
        n_checks++; if (bus.o_upd_count !== 32'd5) $display("[TB] FAIL stall_branch_count: got %0d, expected 5", bus.o_upd_count); else n_pass++;
        bus.i_stall = 1'b0;
        bus.i_branch_target = 32'h40;
        bus.i_jump          = 1'b1;
        bus.i_jump_target   = 32'h100;
        tick();
        n_checks++; if (bus.o_pc !== 32'h40) $display("[TB] FAIL branch_over_jump: got %h, expected %h", bus.o_pc, 32'h40); else n_pass++;
        bus.i_branch_taken = 1'b0;
        bus.i_jump_target  = 32'h203;
        tick();
        n_checks++; if (bus.o_pc !== 32'h203) $display("[TB] FAIL jump_unaligned: got %h, expected %h", bus.o_pc, 32'h203); else n_pass++;
        n_checks++; if (bus.o_pc_plus4 !== 32'h207) $display("[TB] FAIL jump_plus4: got %h, expected %h", bus.o_pc_plus4, 32'h207); else n_pass++;
        n_checks++; if (bus.o_upd_count !== 32'd7) $display("[TB] FAIL jump_count: got %0d, expected 7", bus.o_upd_count); else n_pass++;
        bus.i_jump = 1'b0;
    endtask

    task automatic test_step();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_dbg_step = 1'b1;
        bus.i_stall    = 1'b1;
        tick();
        bus.i_dbg_step = 1'b0;
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL step_enter_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        tick();
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL step_stall_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        n_checks++; if (bus.o_step_done !== 1'b0) $display("[TB] FAIL step_stall_done: got %b, expected 0", bus.o_step_done); else n_pass++;
        bus.i_stall = 1'b0;
        tick();
        n_checks++; if (bus.o_pc !== 32'h4) $display("[TB] FAIL step_pc: got %h, expected %h", bus.o_pc, 32'h4); else n_pass++;
        n_checks++; if (bus.o_step_done !== 1'b1) $display("[TB] FAIL step_done_pulse: got %b, expected 1", bus.o_step_done); else n_pass++;
        n_checks++; if (bus.o_upd_count !== 32'd1) $display("[TB] FAIL step_count: got %0d, expected 1", bus.o_upd_count); else n_pass++;
        tick();
        n_checks++; if (bus.o_step_done !== 1'b0) $display("[TB] FAIL step_done_width: got %b, expected 0", bus.o_step_done); else n_pass++;
        n_checks++; if (bus.o_pc !== 32'h4) $display("[TB] FAIL step_back_to_wait: got %h, expected %h", bus.o_pc, 32'h4); else n_pass++;
    endtask

    task automatic test_halt();
        bus.i_dbg_cont = 1'b1;
        tick();
        bus.i_dbg_cont    = 1'b0;
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'h20;
        tick();
        n_checks++; if (bus.o_pc !== 32'h20) $display("[TB] FAIL halt_setup_pc: got %h, expected %h", bus.o_pc, 32'h20); else n_pass++;
        bus.i_jump_target = 32'h300;
        bus.i_halt_detect = 1'b1;
        tick();
        bus.i_halt_detect = 1'b0;
        bus.i_jump        = 1'b0;
        n_checks++; if (bus.o_pc !== 32'h20) $display("[TB] FAIL halt_pc_hold: got %h, expected %h", bus.o_pc, 32'h20); else n_pass++;
        n_checks++; if (bus.o_halted !== 1'b1) $display("[TB] FAIL halt_flag: got %b, expected 1", bus.o_halted); else n_pass++;
        bus.i_dbg_cont = 1'b1;
        bus.i_dbg_step = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.o_pc !== 32'h20) $display("[TB] FAIL halt_ignore_dbg: got %h, expected %h", bus.o_pc, 32'h20); else n_pass++;
        n_checks++; if (bus.o_halted !== 1'b1) $display("[TB] FAIL halt_sticky: got %b, expected 1", bus.o_halted); else n_pass++;
        n_checks++; if (bus.o_upd_count !== 32'd2) $display("[TB] FAIL halt_count: got %0d, expected 2", bus.o_upd_count); else n_pass++;
        bus.i_dbg_step = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_dbg_cont = 1'b0;
        n_checks++; if (bus.o_halted !== 1'b0) $display("[TB] FAIL halt_reset_flag: got %b, expected 0", bus.o_halted); else n_pass++;
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL halt_reset_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        tick();
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL reset_over_cont: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp8;
        bus.i_dbg_cont  = 1'b1;
        bus8.i_dbg_cont = 1'b1;
        tick();
        bus.i_dbg_cont    = 1'b0;
        bus8.i_dbg_cont   = 1'b0;
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'hFFFF_FFFC;
        tick();
        bus.i_jump = 1'b0;
        n_checks++; if (bus8.o_pc !== 8'h00) $display("[TB] FAIL wrap8_pc: got %h, expected %h", bus8.o_pc, 8'h00); else n_pass++;
        n_checks++; if (bus8.o_upd_count !== 32'd1) $display("[TB] FAIL wrap8_count: got %0d, expected 1", bus8.o_upd_count); else n_pass++;
        exp8 = HIST_ON ? 8'hFC : 8'h00;
        n_checks++; if (bus8.o_hist_pc !== exp8) $display("[TB] FAIL wrap8_hist0: got %h, expected %h", bus8.o_hist_pc, exp8); else n_pass++;
        n_checks++; if (bus.o_pc_plus4 !== 32'h0) $display("[TB] FAIL wrap32_plus4: got %h, expected %h", bus.o_pc_plus4, 32'h0); else n_pass++;
        tick();
        n_checks++; if (bus.o_pc !== 32'h0) $display("[TB] FAIL wrap32_pc: got %h, expected %h", bus.o_pc, 32'h0); else n_pass++;
        n_checks++; if (bus8.o_pc !== 8'h04) $display("[TB] FAIL wrap8_next: got %h, expected %h", bus8.o_pc, 8'h04); else n_pass++;
        bus8.i_hist_idx = 2'd1;
        #1;
        n_checks++; if (bus8.o_hist_pc !== exp8) $display("[TB] FAIL wrap8_hist1: got %h, expected %h", bus8.o_hist_pc, exp8); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_run();
        test_stall_redirect();
        test_step();
        test_halt();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the bare PC register with next-PC selection: sequential increment, branch and jump redirect, and hazard stall. It also adds a debug run/step/halt state machine driven by the debug unit, and a count of PC updates. It sits at the head of IF, feeding instruction-memory address and the IF/ID PC+4 field.

## Interface

- MSB, 32, PC width in bits
- RESET_PC, 0, PC value loaded on reset
- INSTR_BYTES, 4, sequential increment
- HIST_DEPTH, 8, PC history entries (power of two, ≥2; used only with PC_HISTORY_EN)

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hazard-unit stall request
- i_branch_taken  in  1  branch resolved taken
- i_branch_target  in  MSB  branch target address
- i_jump  in  1  jump decoded
- i_jump_target  in  MSB  jump target address
- i_halt_detect  in  1  HALT instruction decoded
- i_dbg_cont  in  1  debug: run continuously
- i_dbg_step  in  1  debug: execute one PC update
- i_hist_idx  in  $clog2(HIST_DEPTH)  history read index, 0 = newest
- o_pc  out  MSB  current PC
- o_pc_plus4  out  MSB  o_pc + INSTR_BYTES, combinational
- o_halted  out  1  high in HALT state
- o_step_done  out  1  one-cycle pulse when a STEP update occurs
- o_upd_count  out  32  number of PC updates since reset
- o_hist_pc  out  MSB  history entry at i_hist_idx

## Operation

- FSM states: WAIT, RUN, STEP, HALT. Reset state is WAIT.
- WAIT transitions:
  - i_dbg_cont → RUN
  - else i_dbg_step → STEP
  - cont has priority over step
- RUN transitions: i_halt_detect → HALT; otherwise stay in RUN.
- STEP transitions:
  - i_halt_detect → HALT
  - else a PC update → WAIT, with o_step_done=1 on that edge's output cycle
  - stalled with no redirect → remain in STEP
- HALT leaves only on i_rst. i_dbg_* are ignored in HALT.
- active = state is RUN or STEP, and i_halt_detect=0.
- update = active && (!i_stall || i_branch_taken || i_jump). A redirect overrides the stall, so a flush is never lost.
- On update, next-PC priority:
  - i_branch_taken → i_branch_target
  - else i_jump → i_jump_target
  - else o_pc + INSTR_BYTES
- Without update, o_pc holds. Targets are taken unaligned, exactly as supplied.
- Arithmetic is modulo 2^MSB: PC wraps from 2^MSB−INSTR_BYTES to 0. o_upd_count wraps at 2^32.
- A HALT detected in the same cycle as a redirect: halt wins and the PC holds.

## Timing

- Reset values:
  - o_pc = RESET_PC
  - o_pc_plus4 = RESET_PC + INSTR_BYTES
  - o_halted = 0
  - o_step_done = 0
  - o_upd_count = 0
  - all history entries = 0
  - state = WAIT
- Latency: redirect/step inputs sampled at edge N, and the new o_pc is visible after edge N. o_pc_plus4 and o_hist_pc are combinational.
- o_halted rises the cycle after the halt-detect edge.
- o_step_done is exactly one cycle wide per step.
- i_rst asserted in any state: takes effect at the next edge and overrides all other inputs.

## Configuration

- PC_HISTORY_EN defined:
  - circular buffer of HIST_DEPTH entries
  - on each update, the outgoing o_pc is written at the head pointer and the pointer advances with wrap
  - o_hist_pc = entry (head−1−i_hist_idx) mod HIST_DEPTH
- PC_HISTORY_EN undefined: no storage; o_hist_pc tied to 0. Ports are present in both builds.

## Test plan

- Reset, then i_dbg_cont pulse, no stall, 4 cycles → o_pc 0,4,8,12,16; o_upd_count=4.
- RUN with i_stall=1 for 3 cycles at o_pc=0x10 → o_pc holds 0x10. Then i_stall=1 with i_branch_taken=1, target 0x80 → o_pc=0x80.
- i_branch_taken=1 (target 0x40) and i_jump=1 (target 0x100) in the same cycle → o_pc=0x40.
- From WAIT, i_dbg_step with i_stall=1 for 2 cycles, then released → one update, o_step_done pulses once, state WAIT, o_pc +4.
- i_halt_detect at o_pc=0x20 with a concurrent jump → o_pc stays 0x20, o_halted=1. Further i_dbg_cont is ignored until i_rst.
- MSB=8, RESET_PC=0xFC, run 1 cycle → o_pc=0x00 (wrap). With PC_HISTORY_EN, i_hist_idx=0 → o_hist_pc=0xFC.
